// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller beside decode: load-use bubbles, multi-cycle
// data memory freeze with timeout, taken-branch squash and HLT/resume.
module hazard_stall_unit #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       src1,
    input  logic [2:0]       src2,
    input  logic             src1_used,
    input  logic             src2_used,
    input  logic [2:0]       ex_dest,
    input  logic             ex_wb,
    input  logic             ex_mem_read,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic             halt_dec,
    input  logic             resume,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             freeze,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic load_use;
    logic mem_stall;

    assign load_use  = ex_mem_read & ex_wb &
                       ((src1_used & (src1 == ex_dest)) | (src2_used & (src2 == ex_dest)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        halted      = 1'b0;

        if (state_q == ST_MEM_WAIT) begin
            freeze  = ~mem_ready;
            pc_we   = mem_ready;
            ifid_we = mem_ready;
            if (mem_ready) begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                timeout_d  = 1'b1;
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else if (state_q == ST_HALTED && !resume) begin
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else begin
            // RUN, including the resume cycle out of HALTED.
            state_d = ST_RUN;
            if (mem_stall) begin
                freeze  = 1'b1;
                state_d = ST_MEM_WAIT;
            end else if (branch_taken) begin
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                flush_ifid  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
            end else if (halt_dec) begin
                idex_bubble = 1'b1;
                state_d     = ST_HALTED;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        end

        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            flush_ifid  = 1'b0;
            freeze      = 1'b0;
            halted      = 1'b0;
        end

        stall_d = stall_q;
        if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed hazard scenarios plus random traffic,
// scored against a rule-level reference model through an expected queue.
module tb_hazard_stall_unit;

    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 8;
    localparam int EXP_W    = 7 + CNT_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic       rst;
        logic [2:0] src1;
        logic [2:0] src2;
        logic       src1_used;
        logic       src2_used;
        logic [2:0] ex_dest;
        logic       ex_wb;
        logic       ex_mem_read;
        logic       mem_req;
        logic       mem_ready;
        logic       branch_taken;
        logic       halt_dec;
        logic       resume;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       src1 = '0, src2 = '0, ex_dest = '0;
    logic             src1_used = 0, src2_used = 0, ex_wb = 0, ex_mem_read = 0;
    logic             mem_req = 0, mem_ready = 0, branch_taken = 0, halt_dec = 0, resume = 0;
    logic             pc_we, ifid_we, idex_bubble, flush_ifid, freeze, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .src1_used(src1_used), .src2_used(src2_used),
        .ex_dest(ex_dest), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .halt_dec(halt_dec), .resume(resume),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble),
        .flush_ifid(flush_ifid), .freeze(freeze), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipeline mode, cycles spent waiting on memory, sticky flag, stall total.
    int m_mode    = M_RUN;
    int m_waited  = 0;
    bit m_timeout = 0;
    int m_stalls  = 0;

    task automatic model_push(input stim_t s);
        bit pc, ifid, bub, fl, frz, hl, lu, ms;
        if (s.rst) begin
            m_mode = M_RUN; m_waited = 0; m_timeout = 0; m_stalls = 0;
            exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(0)});
            return;
        end
        lu = s.ex_mem_read && s.ex_wb &&
             ((s.src1_used && s.src1 == s.ex_dest) || (s.src2_used && s.src2 == s.ex_dest));
        ms = s.mem_req && !s.mem_ready;
        {pc, ifid, bub, fl, frz, hl} = '0;
        if (m_mode == M_WAIT) begin
            frz = !s.mem_ready; pc = s.mem_ready; ifid = s.mem_ready;
        end else if (m_mode == M_HALT && !s.resume) begin
            bub = 1; hl = 1;
        end else if (ms) frz = 1;
        else if (s.branch_taken) begin
            pc = 1; ifid = 1; fl = 1; bub = 1;
        end else if (lu || s.halt_dec) bub = 1;
        else begin
            pc = 1; ifid = 1;
        end
        exp_q.push_back({pc, ifid, bub, fl, frz, hl, m_timeout, CNT_W'(m_stalls)});

        if (!pc && m_stalls < CNT_MAX) m_stalls++;
        if (m_mode == M_WAIT) begin
            if (s.mem_ready) begin
                m_mode = M_RUN; m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    m_timeout = 1; m_mode = M_RUN; m_waited = 0;
                end
            end
        end else if (!(m_mode == M_HALT && !s.resume)) begin
            m_mode = M_RUN;
            if (ms) m_mode = M_WAIT;
            else if (!s.branch_taken && !lu && s.halt_dec) m_mode = M_HALT;
        end
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst = s.rst; src1 = s.src1; src2 = s.src2;
        src1_used = s.src1_used; src2_used = s.src2_used; ex_dest = s.ex_dest;
        ex_wb = s.ex_wb; ex_mem_read = s.ex_mem_read; mem_req = s.mem_req;
        mem_ready = s.mem_ready; branch_taken = s.branch_taken;
        halt_dec = s.halt_dec; resume = s.resume;
        model_push(s);
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) drive(s);
    endtask

    function automatic stim_t load_use_stim(input logic u1, input logic u2, input logic wb);
        stim_t s;
        s = '0;
        s.ex_mem_read = 1; s.ex_wb = wb; s.ex_dest = 3'd3;
        s.src1 = 3'd3; s.src1_used = u1; s.src2 = 3'd3; s.src2_used = u2;
        return s;
    endfunction

    function automatic bit chance(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic random_phase(input int n, input int rst_pct);
        stim_t s;
        int rdy_pct;
        rdy_pct = 40;
        for (int i = 0; i < n; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(2, 0))
                    0: rdy_pct = 3;
                    1: rdy_pct = 40;
                    default: rdy_pct = 90;
                endcase
            end
            s.rst          = chance(rst_pct);
            s.src1         = 3'($urandom_range(3, 0));
            s.src2         = 3'($urandom_range(3, 0));
            s.ex_dest      = 3'($urandom_range(3, 0));
            s.src1_used    = chance(70);
            s.src2_used    = chance(50);
            s.ex_wb        = chance(70);
            s.ex_mem_read  = chance(35);
            s.mem_req      = chance(20);
            s.mem_ready    = chance(rdy_pct);
            s.branch_taken = chance(12);
            s.halt_dec     = chance(5);
            s.resume       = chance(25);
            drive(s);
        end
    endtask

    // Monitor: outputs are stable a little after the negedge where inputs change.
    initial begin
        logic [EXP_W-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pc_we, ifid_we, idex_bubble, flush_ifid, freeze, halted,
                         mem_timeout, stall_cycles};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t {pc,ifid,bub,flush,frz,hlt,tmo}: got %b stall=%0d, expected %b stall=%0d",
                             $time, act_v[EXP_W-1 -: 7], act_v[CNT_W-1:0],
                             exp_v[EXP_W-1 -: 7], exp_v[CNT_W-1:0]);
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = '0; s.rst = 1;
        drive(s); drive(s);
        idle(2);

        // Load-use on src1, then the non-hazard variants, then src2.
        drive(load_use_stim(1, 0, 1)); idle(2);
        drive(load_use_stim(0, 0, 1)); idle(1);
        drive(load_use_stim(1, 1, 0)); idle(1);
        drive(load_use_stim(0, 1, 1)); idle(1);

        // Memory busy three cycles, then ready.
        s = '0; s.mem_req = 1;
        drive(s); drive(s); drive(s);
        s.mem_ready = 1; drive(s);
        idle(2);

        // Memory never ready: timeout after MAX_WAIT waiting cycles, flag sticks.
        s = '0; s.mem_req = 1;
        for (int i = 0; i < MAX_WAIT + 3; i++) drive(s);
        s.mem_ready = 1; drive(s);
        idle(3);

        // Branch beats load-use; memory stall beats branch.
        s = load_use_stim(1, 0, 1); s.branch_taken = 1; drive(s);
        idle(1);
        s = '0; s.branch_taken = 1; s.mem_req = 1; drive(s);
        s.mem_ready = 1; drive(s);
        idle(1);

        // Halt, hold, resume with a load-use in the same cycle.
        s = '0; s.halt_dec = 1; drive(s);
        s = '0; s.mem_req = 1; drive(s); drive(s);
        s = load_use_stim(1, 0, 1); s.resume = 1; drive(s);
        idle(2);

        // Halt again and reset mid-HALTED.
        s = '0; s.halt_dec = 1; drive(s);
        idle(3);
        s = '0; s.rst = 1; drive(s);
        idle(2);

        random_phase(1500, 0);
        random_phase(800, 2);
        idle(2);

        @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decides when the pipeline must stall, squash or freeze because forwarding from the execute and memory stages cannot supply an operand in time.
- Covers load-use hazards, a multi-cycle data memory, taken branches and a halt instruction.
- Sits beside the decode stage. It drives PC / IF-ID write enables and the ID-EX bubble that the forwarding path depends on.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MAX_WAIT, 8: maximum consecutive cycles in MEM_WAIT before a timeout is declared.
- CNT_W, 16: width of stall_cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- src1  input  3  decode-stage source register 1 address
- src2  input  3  decode-stage source register 2 address
- src1_used  input  1  decode instruction reads src1
- src2_used  input  1  decode instruction reads src2
- ex_dest  input  3  destination register of the instruction in execute
- ex_wb  input  1  execute instruction writes back
- ex_mem_read  input  1  execute instruction is a load
- mem_req  input  1  memory stage has an access in flight
- mem_ready  input  1  data memory completes the access this cycle
- branch_taken  input  1  branch resolved taken in execute
- halt_dec  input  1  decode instruction is HLT
- resume  input  1  leave the halted state
- pc_we  output  1  PC write enable
- ifid_we  output  1  IF/ID register write enable
- idex_bubble  output  1  load a NOP into ID/EX
- flush_ifid  output  1  clear IF/ID
- freeze  output  1  hold EX/MEM and MEM/WB registers
- halted  output  1  unit is in HALTED
- mem_timeout  output  1  sticky: MAX_WAIT exceeded
- stall_cycles  output  CNT_W  saturating count of cycles with pc_we=0

Behaviour:
- States: RUN, MEM_WAIT, HALTED.
- Outputs are combinational from state and inputs. Counters and flags are registered.
- load_use = ex_mem_read & ex_wb & ((src1_used & src1==ex_dest) | (src2_used & src2==ex_dest)). Register address 0 is not special.
- mem_stall = mem_req & ~mem_ready.
- RUN priority, highest first:
  1. mem_stall: freeze=1, pc_we=0, ifid_we=0, idex_bubble=0, flush_ifid=0. Next state is MEM_WAIT.
  2. branch_taken: pc_we=1, ifid_we=1, flush_ifid=1, idex_bubble=1. Both younger instructions are squashed. Stay in RUN.
  3. load_use: pc_we=0, ifid_we=0, idex_bubble=1. This is exactly one bubble; the next cycle the load is in MEM and forwarding covers it. Stay in RUN.
  4. halt_dec: pc_we=0, ifid_we=0, idex_bubble=1. Next state is HALTED.
  5. Otherwise: pc_we=1, ifid_we=1, all other outputs 0.
- MEM_WAIT:
  - freeze=~mem_ready, pc_we=mem_ready, ifid_we=mem_ready. load_use, branch_taken and halt_dec are ignored.
  - mem_ready moves the state to RUN.
  - wait_cnt increments each MEM_WAIT cycle. On reaching MAX_WAIT, mem_timeout sets and the state forces to RUN. mem_timeout stays set until reset.
- HALTED:
  - pc_we=0, ifid_we=0, idex_bubble=1, halted=1.
  - resume moves the state to RUN, and outputs in that cycle already follow RUN rules.
  - mem_stall in HALTED is ignored, because the pipeline has drained.
- stall_cycles: +1 on each clock edge where pc_we==0 and rst==0. It saturates at all-ones and never wraps.
- wait_cnt clears on leaving MEM_WAIT.
- Reset (asynchronous, any cycle, including mid-MEM_WAIT or HALTED):
  - state RUN, wait_cnt 0, mem_timeout 0, stall_cycles 0.
  - While rst=1: pc_we=0, ifid_we=0, idex_bubble=1, flush_ifid=0, freeze=0, halted=0.
- Simultaneous events:
  - mem_stall with branch_taken: freeze wins. The branch is re-evaluated when the pipeline releases, since the EX registers are held.
  - branch_taken with load_use: the branch wins and the dependent instruction is squashed.

Test Plan:
- Load r3 in EX, decode reads src1=3 with src1_used=1 -> exactly one cycle with pc_we=0, idex_bubble=1. The next cycle has pc_we=1, and stall_cycles=1.
- Same stimulus with src1_used=0, or ex_wb=0 -> no stall, pc_we=1 throughout.
- mem_req=1 with mem_ready low for 3 cycles, then high -> freeze=1 for 3 cycles, released on the ready cycle, and stall_cycles=3.
- mem_ready never rises with MAX_WAIT=8 -> after 8 MEM_WAIT cycles mem_timeout=1 and the state returns to RUN. The flag persists until rst.
- branch_taken together with load_use -> flush_ifid=1, idex_bubble=1, pc_we=1, and no extra stall cycle.
- halt_dec=1 -> halted=1 and pc_we=0 until resume. Asserting rst mid-HALTED clears halted and stall_cycles to 0 immediately, with no clock edge needed.
